// File: rtl/tdm_demux_1x4_if.sv
// tdm_demux_1x4_if: serial TDM input and channel outputs of tdm_demux_1x4.
// Ports: din/en/fsync/err_clr (to demux); y/valid/sel/locked/frame_err
// (from demux); par_err exists only with TDM_DEMUX_PARITY_EN defined.
interface tdm_demux_1x4_if;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SELW = 3;
`else
    localparam int SELW = 2;
`endif

    logic            din;
    logic            en;
    logic            fsync;
    logic            err_clr;
    logic [3:0]      y;
    logic            valid;
    logic [SELW-1:0] sel;
    logic            locked;
    logic            frame_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic            par_err;
`endif

`ifdef TDM_DEMUX_PARITY_EN
    modport master (
        output din, en, fsync, err_clr,
        input  y, valid, sel, locked, frame_err, par_err
    );
    modport slave (
        input  din, en, fsync, err_clr,
        output y, valid, sel, locked, frame_err, par_err
    );
`else
    modport master (
        output din, en, fsync, err_clr,
        input  y, valid, sel, locked, frame_err
    );
    modport slave (
        input  din, en, fsync, err_clr,
        output y, valid, sel, locked, frame_err
    );
`endif
endinterface

// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: 1-to-4 TDM serial demultiplexer with frame sync hunt,
// sticky framing error and optional even-parity slot (TDM_DEMUX_PARITY_EN).
// Ports: clk, rst_n (async, active low), bus (tdm_demux_1x4_if.slave).
module tdm_demux_1x4 (
    input  logic              clk,
    input  logic              rst_n,
    tdm_demux_1x4_if.slave    bus
);
`ifdef TDM_DEMUX_PARITY_EN
    localparam int              SELW = 3;
    localparam logic [SELW-1:0] LAST = 3'd4;
`else
    localparam int              SELW = 2;
    localparam logic [SELW-1:0] LAST = 2'd3;
`endif

    typedef enum logic {HUNT, RUN} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [3:0]      shadow_q, shadow_d;
    logic [3:0]      y_q, y_d;
    logic            valid_q, valid_d;
    logic            locked_q, locked_d;
    logic            ferr_q, ferr_d;
    logic            err_set;
    logic            perr_q, perr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            sel_q    <= '0;
            shadow_q <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        y_d      = y_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        err_set  = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.fsync) begin
                        shadow_d[0] = bus.din;
                        sel_d       = 1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (sel_q == '0) begin
                        if (bus.fsync) begin
                            shadow_d[0] = bus.din;
                            sel_d       = 1;
                        end else begin
                            // Missing sync: drop lock and re-hunt.
                            err_set = 1'b1;
                            sel_d   = '0;
                            state_d = HUNT;
                        end
                    end else if (bus.fsync) begin
                        // Early sync: this bit restarts the frame.
                        err_set     = 1'b1;
                        shadow_d[0] = bus.din;
                        sel_d       = 1;
                    end else if (sel_q == LAST) begin
                        sel_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        // Even parity: slot 4 equals XOR of slots 0-3.
                        if ((^shadow_q) == bus.din) begin
                            y_d     = shadow_q;
                            valid_d = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
`else
                        y_d     = {bus.din, shadow_q[2:0]};
                        valid_d = 1'b1;
`endif
                    end else begin
                        shadow_d[sel_q[1:0]] = bus.din;
                        sel_d = sel_q + 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    sel_d   = '0;
                end
            endcase
        end
        // Set has priority over clear on the same edge.
        ferr_d   = err_set | (ferr_q & ~bus.err_clr);
        locked_d = (state_d == RUN);
    end

    always_comb begin
        bus.y         = y_q;
        bus.valid     = valid_q;
        bus.sel       = sel_q;
        bus.locked    = locked_q;
        bus.frame_err = ferr_q;
`ifdef TDM_DEMUX_PARITY_EN
        bus.par_err   = perr_q;
`endif
    end

`ifndef TDM_DEMUX_PARITY_EN
    logic unused_perr;
    assign unused_perr = perr_q;
`endif
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb_tdm_demux_1x4: directed self-checking bench for tdm_demux_1x4.
// Scenarios: reset/hunt, basic, back-to-back, early sync, missing sync, mid-frame reset, parity.
module tb_tdm_demux_1x4;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SELW = 3;
`else
    localparam int SELW = 2;
`endif

    logic clk;
    logic rst_n;
    int   nvec;
    int   nmis;
    int   vcnt;
    int   v0;

    tdm_demux_1x4_if bus ();

    tdm_demux_1x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.valid === 1'b1) vcnt++;

    task automatic slot(input logic d, input logic f,
                        input logic e = 1'b1, input logic c = 1'b0);
        @(negedge clk);
        bus.din     = d;
        bus.fsync   = f;
        bus.en      = e;
        bus.err_clr = c;
        @(posedge clk);
        #1;
    endtask

    // Final data slot, plus the matching parity slot when enabled.
    task automatic finish_frame(input logic d3, input logic [2:0] lo);
        slot(d3, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        slot(^{d3, lo}, 1'b0);
`else
        if (lo === 3'bxxx) $display("note: unknown lo");
`endif
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.din     = 1'b0;
        bus.en      = 1'b0;
        bus.fsync   = 1'b0;
        bus.err_clr = 1'b0;
        repeat (2) @(negedge clk);
        nvec++; if (bus.y !== 4'b0000) begin nmis++; $display("FAIL rst_y got %b want 0000", bus.y); end
        nvec++; if (bus.valid !== 1'b0) begin nmis++; $display("FAIL rst_valid got %b want 0", bus.valid); end
        nvec++; if (bus.sel !== SELW'(0)) begin nmis++; $display("FAIL rst_sel got %0d want 0", bus.sel); end
        nvec++; if (bus.locked !== 1'b0) begin nmis++; $display("FAIL rst_locked got %b want 0", bus.locked); end
        nvec++; if (bus.frame_err !== 1'b0) begin nmis++; $display("FAIL rst_ferr got %b want 0", bus.frame_err); end
        rst_n = 1'b1;
        slot(1'b1, 1'b0);
        slot(1'b1, 1'b0);
        nvec++; if (bus.locked !== 1'b0) begin nmis++; $display("FAIL hunt_locked got %b want 0", bus.locked); end
        nvec++; if (bus.sel !== SELW'(0)) begin nmis++; $display("FAIL hunt_sel got %0d want 0", bus.sel); end
    endtask

    task automatic test_basic();
        v0 = vcnt;
        slot(1'b1, 1'b1);
        nvec++; if (bus.sel !== SELW'(1)) begin nmis++; $display("FAIL basic_sel1 got %0d want 1", bus.sel); end
        nvec++; if (bus.locked !== 1'b1) begin nmis++; $display("FAIL basic_lock got %b want 1", bus.locked); end
        slot(1'b0, 1'b0);
        slot(1'b1, 1'b0);
        nvec++; if (bus.valid !== 1'b0) begin nmis++; $display("FAIL basic_early_valid got %b want 0", bus.valid); end
        finish_frame(1'b1, 3'b101);
        nvec++; if (bus.y !== 4'b1101) begin nmis++; $display("FAIL basic_y got %b want 1101", bus.y); end
        nvec++; if (bus.valid !== 1'b1) begin nmis++; $display("FAIL basic_valid got %b want 1", bus.valid); end
        nvec++; if (bus.frame_err !== 1'b0) begin nmis++; $display("FAIL basic_ferr got %b want 0", bus.frame_err); end
        nvec++; if (bus.sel !== SELW'(0)) begin nmis++; $display("FAIL basic_wrap got %0d want 0", bus.sel); end
        slot(1'b0, 1'b0, 1'b0);
        nvec++; if (bus.valid !== 1'b0) begin nmis++; $display("FAIL basic_pulse got %b want 0", bus.valid); end
        nvec++; if (bus.y !== 4'b1101) begin nmis++; $display("FAIL basic_hold got %b want 1101", bus.y); end
        nvec++; if (vcnt - v0 !== 1) begin nmis++; $display("FAIL basic_npulse got %0d want 1", vcnt - v0); end
    endtask

    task automatic test_back_to_back();
        v0 = vcnt;
        slot(1'b0, 1'b1);
        slot(1'b1, 1'b0, 1'b0);
        nvec++; if (bus.sel !== SELW'(1)) begin nmis++; $display("FAIL b2b_gap_sel got %0d want 1", bus.sel); end
        slot(1'b0, 1'b0);
        slot(1'b1, 1'b1, 1'b0);
        slot(1'b0, 1'b0);
        slot(1'b1, 1'b0, 1'b0);
        nvec++; if (bus.sel !== SELW'(3)) begin nmis++; $display("FAIL b2b_gap_sel3 got %0d want 3", bus.sel); end
        nvec++; if (bus.valid !== 1'b0) begin nmis++; $display("FAIL b2b_gap_valid got %b want 0", bus.valid); end
        finish_frame(1'b1, 3'b000);
        nvec++; if (bus.y !== 4'b1000) begin nmis++; $display("FAIL b2b_y1 got %b want 1000", bus.y); end
        slot(1'b0, 1'b0, 1'b0);
        nvec++; if (bus.y !== 4'b1000) begin nmis++; $display("FAIL b2b_hold got %b want 1000", bus.y); end
        slot(1'b1, 1'b1);
        slot(1'b0, 1'b0, 1'b0);
        slot(1'b0, 1'b0);
        slot(1'b0, 1'b0, 1'b0);
        slot(1'b0, 1'b0);
        slot(1'b0, 1'b0, 1'b0);
        finish_frame(1'b0, 3'b001);
        nvec++; if (bus.y !== 4'b0001) begin nmis++; $display("FAIL b2b_y2 got %b want 0001", bus.y); end
        slot(1'b0, 1'b0, 1'b0);
        nvec++; if (vcnt - v0 !== 2) begin nmis++; $display("FAIL b2b_npulse got %0d want 2", vcnt - v0); end
    endtask

    task automatic test_early_sync();
        v0 = vcnt;
        slot(1'b1, 1'b1);
        slot(1'b0, 1'b0);
        slot(1'b0, 1'b1);
        nvec++; if (bus.frame_err !== 1'b1) begin nmis++; $display("FAIL early_ferr got %b want 1", bus.frame_err); end
        nvec++; if (bus.sel !== SELW'(1)) begin nmis++; $display("FAIL early_sel got %0d want 1", bus.sel); end
        nvec++; if (bus.locked !== 1'b1) begin nmis++; $display("FAIL early_lock got %b want 1", bus.locked); end
        slot(1'b1, 1'b0);
        slot(1'b1, 1'b0);
        nvec++; if (vcnt - v0 !== 0) begin nmis++; $display("FAIL early_novalid got %0d want 0", vcnt - v0); end
        finish_frame(1'b0, 3'b110);
        nvec++; if (bus.y !== 4'b0110) begin nmis++; $display("FAIL early_y got %b want 0110", bus.y); end
        nvec++; if (bus.valid !== 1'b1) begin nmis++; $display("FAIL early_valid got %b want 1", bus.valid); end
    endtask

    task automatic test_missing_sync();
        slot(1'b1, 1'b1, 1'b1, 1'b1);
        nvec++; if (bus.frame_err !== 1'b0) begin nmis++; $display("FAIL miss_clr0 got %b want 0", bus.frame_err); end
        slot(1'b0, 1'b0);
        slot(1'b1, 1'b0);
        finish_frame(1'b0, 3'b101);
        nvec++; if (bus.y !== 4'b0101) begin nmis++; $display("FAIL miss_y got %b want 0101", bus.y); end
        slot(1'b1, 1'b0);
        nvec++; if (bus.frame_err !== 1'b1) begin nmis++; $display("FAIL miss_ferr got %b want 1", bus.frame_err); end
        nvec++; if (bus.locked !== 1'b0) begin nmis++; $display("FAIL miss_lock got %b want 0", bus.locked); end
        nvec++; if (bus.sel !== SELW'(0)) begin nmis++; $display("FAIL miss_sel got %0d want 0", bus.sel); end
        nvec++; if (bus.valid !== 1'b0) begin nmis++; $display("FAIL miss_valid got %b want 0", bus.valid); end
        slot(1'b0, 1'b0, 1'b1, 1'b1);
        nvec++; if (bus.frame_err !== 1'b0) begin nmis++; $display("FAIL miss_clr got %b want 0", bus.frame_err); end
        slot(1'b1, 1'b1);
        slot(1'b1, 1'b1, 1'b1, 1'b1);
        nvec++; if (bus.frame_err !== 1'b1) begin nmis++; $display("FAIL miss_setwins got %b want 1", bus.frame_err); end
        slot(1'b0, 1'b0, 1'b1, 1'b1);
        nvec++; if (bus.frame_err !== 1'b0) begin nmis++; $display("FAIL miss_clr2 got %b want 0", bus.frame_err); end
    endtask

    task automatic test_reset_mid_frame();
        slot(1'b1, 1'b1);
        slot(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++; if (bus.y !== 4'b0000) begin nmis++; $display("FAIL arst_y got %b want 0000", bus.y); end
        nvec++; if (bus.sel !== SELW'(0)) begin nmis++; $display("FAIL arst_sel got %0d want 0", bus.sel); end
        nvec++; if (bus.locked !== 1'b0) begin nmis++; $display("FAIL arst_lock got %b want 0", bus.locked); end
        nvec++; if (bus.frame_err !== 1'b0) begin nmis++; $display("FAIL arst_ferr got %b want 0", bus.frame_err); end
        nvec++; if (bus.valid !== 1'b0) begin nmis++; $display("FAIL arst_valid got %b want 0", bus.valid); end
        @(negedge clk);
        rst_n = 1'b1;
        v0 = vcnt;
        repeat (5) slot(1'b1, 1'b0);
        nvec++; if (vcnt - v0 !== 0) begin nmis++; $display("FAIL arst_nosync got %0d want 0", vcnt - v0); end
        nvec++; if (bus.locked !== 1'b0) begin nmis++; $display("FAIL arst_hunt got %b want 0", bus.locked); end
        slot(1'b1, 1'b1);
        slot(1'b0, 1'b0);
        slot(1'b0, 1'b0);
        finish_frame(1'b1, 3'b001);
        nvec++; if (bus.y !== 4'b1001) begin nmis++; $display("FAIL arst_y2 got %b want 1001", bus.y); end
        nvec++; if (bus.valid !== 1'b1) begin nmis++; $display("FAIL arst_valid2 got %b want 1", bus.valid); end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        slot(1'b1, 1'b1);
        slot(1'b1, 1'b0);
        slot(1'b0, 1'b0);
        slot(1'b1, 1'b0);
        slot(1'b1, 1'b0);
        nvec++; if (bus.y !== 4'b1011) begin nmis++; $display("FAIL par_y got %b want 1011", bus.y); end
        nvec++; if (bus.valid !== 1'b1) begin nmis++; $display("FAIL par_valid got %b want 1", bus.valid); end
        nvec++; if (bus.par_err !== 1'b0) begin nmis++; $display("FAIL par_ok got %b want 0", bus.par_err); end
        slot(1'b1, 1'b1);
        slot(1'b1, 1'b0);
        slot(1'b0, 1'b0);
        slot(1'b1, 1'b0);
        slot(1'b0, 1'b0);
        nvec++; if (bus.par_err !== 1'b1) begin nmis++; $display("FAIL par_err got %b want 1", bus.par_err); end
        nvec++; if (bus.valid !== 1'b0) begin nmis++; $display("FAIL par_novalid got %b want 0", bus.valid); end
        nvec++; if (bus.y !== 4'b1011) begin nmis++; $display("FAIL par_hold got %b want 1011", bus.y); end
        slot(1'b0, 1'b0, 1'b0);
        nvec++; if (bus.par_err !== 1'b0) begin nmis++; $display("FAIL par_pulse got %b want 0", bus.par_err); end
    endtask
`endif

    initial begin
        nvec = 0;
        nmis = 0;
        vcnt = 0;
        v0   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_early_sync();
        test_missing_sync();
        test_reset_mid_frame();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
